// File: rtl/spectrum_pkg.sv
// Shared constants for the spectrum path: line geometry, the log-magnitude
// stage latency and sample width, plus the line-buffer state encoding.
package spectrum_pkg;

   localparam int NBINS   = 256;
   localparam int ADDR_W  = 8;
   localparam int LOG_LAT = 3;
   localparam int MAG_W   = 8;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } line_state_e;

endpackage

// File: rtl/spectrum_line_buffer_if.sv
// Bin stream, reader port and status of the spectrum line buffer.
// master = upstream/reader side, slave = the line buffer itself.
interface spectrum_line_buffer_if;
   import spectrum_pkg::*;

   logic              ready;
   logic              bin_valid;
   logic              bin_last;
   logic [MAG_W-1:0]  log_mag;
   logic [ADDR_W-1:0] rd_addr;
   logic [MAG_W-1:0]  rd_data;
   logic              line_ready;
   logic              line_ack;
   logic              overflow;
   logic [15:0]       line_count;

   modport master (
      output ready, bin_valid, bin_last, log_mag, rd_addr, line_ack,
      input  rd_data, line_ready, overflow, line_count
   );

   modport slave (
      input  ready, bin_valid, bin_last, log_mag, rd_addr, line_ack,
      output rd_data, line_ready, overflow, line_count
   );

endinterface

// File: rtl/spectrum_bank_ram.sv
// Two-bank sample store: one write port, one registered read port.
// Address is {bank, bin}. Contents survive reset; only the read register clears.
module spectrum_bank_ram #(
   parameter int NBINS  = spectrum_pkg::NBINS,
   parameter int ADDR_W = spectrum_pkg::ADDR_W,
   parameter int MAG_W  = spectrum_pkg::MAG_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   wr_addr,
   input  logic [MAG_W-1:0]  wr_data,
   input  logic [ADDR_W:0]   rd_addr,
   output logic [MAG_W-1:0]  rd_data
);
   import spectrum_pkg::*;

   logic [MAG_W-1:0] mem_q [2*NBINS];
   logic [MAG_W-1:0] rd_data_d;
   logic [MAG_W-1:0] rd_data_q;

   // Storage write; deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read mux feeding the output register.
   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   // Read register, one cycle of latency, cleared by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_data_q <= {MAG_W{1'b0}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/spectrum_line_buffer.sv
// Ping-pong line buffer behind the log-magnitude stage. Aligns valid/last
// with the stage output, writes a line into one bank while the reader holds
// the other, and hands lines over with a line_ready/line_ack handshake.
module spectrum_line_buffer #(
   parameter int NBINS   = spectrum_pkg::NBINS,
   parameter int ADDR_W  = spectrum_pkg::ADDR_W,
   parameter int LOG_LAT = spectrum_pkg::LOG_LAT
) (
   input  logic                   clk,
   input  logic                   resetn,
   spectrum_line_buffer_if.slave  bus
);
   import spectrum_pkg::*;

   logic [LOG_LAT-1:0] valid_d_q, valid_d_d;
   logic [LOG_LAT-1:0] last_d_q,  last_d_d;
   logic [ADDR_W-1:0]  wr_ptr_q,  wr_ptr_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   line_state_e        state_q,   state_d;
   logic               line_ready_q, line_ready_d;
   logic               overflow_q,   overflow_d;
   logic [15:0]        line_count_q, line_count_d;

   logic               wr_en_s;
   logic               complete_s;

   // A sample lands when the stage advances and its delayed valid is set.
   assign wr_en_s    = bus.ready & valid_d_q[LOG_LAT-1];
   assign complete_s = wr_en_s & (last_d_q[LOG_LAT-1] |
                                  (wr_ptr_q == ADDR_W'(NBINS - 1)));

   // Valid/last delay lines advance only with the log-magnitude stage.
   always_comb begin
      valid_d_d = valid_d_q;
      last_d_d  = last_d_q;
      if (bus.ready) begin
         valid_d_d[0] = bus.bin_valid;
         last_d_d[0]  = bus.bin_last;
         for (int i = 1; i < LOG_LAT; i++) begin
            valid_d_d[i] = valid_d_q[i-1];
            last_d_d[i]  = last_d_q[i-1];
         end
      end else begin
         valid_d_d = valid_d_q;
         last_d_d  = last_d_q;
      end
   end

   // Write pointer: step per write, back to bin 0 after a line completes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (complete_s) begin
         wr_ptr_d = {ADDR_W{1'b0}};
      end else if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
   end

   // Line handover: publish into EMPTY, swap-on-ack in HELD, else drop.
   always_comb begin
      state_d      = state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      overflow_d   = overflow_q;
      line_count_d = line_count_q;
      case (state_q)
         ST_EMPTY: begin
            if (complete_s) begin
               wr_bank_d    = ~wr_bank_q;
               rd_bank_d    = ~rd_bank_q;
               line_count_d = line_count_q + 16'd1;
               state_d      = ST_HELD;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_HELD: begin
            if (complete_s && bus.line_ack) begin
               wr_bank_d    = ~wr_bank_q;
               rd_bank_d    = ~rd_bank_q;
               line_count_d = line_count_q + 16'd1;
               state_d      = ST_HELD;
            end else if (complete_s) begin
               // Reader still busy: the new line is lost, its bank is reused.
               overflow_d = 1'b1;
               state_d    = ST_HELD;
            end else if (bus.line_ack) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_HELD;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      line_ready_d = (state_d == ST_HELD);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_d_q    <= {LOG_LAT{1'b0}};
         last_d_q     <= {LOG_LAT{1'b0}};
         wr_ptr_q     <= {ADDR_W{1'b0}};
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         state_q      <= ST_EMPTY;
         line_ready_q <= 1'b0;
         overflow_q   <= 1'b0;
         line_count_q <= 16'd0;
      end else begin
         valid_d_q    <= valid_d_d;
         last_d_q     <= last_d_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         state_q      <= state_d;
         line_ready_q <= line_ready_d;
         overflow_q   <= overflow_d;
         line_count_q <= line_count_d;
      end
   end

   spectrum_bank_ram #(
      .NBINS  (NBINS),
      .ADDR_W (ADDR_W),
      .MAG_W  (MAG_W)
   ) u_ram (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_en_s),
      .wr_addr ({wr_bank_q, wr_ptr_q}),
      .wr_data (bus.log_mag),
      .rd_addr ({rd_bank_q, bus.rd_addr}),
      .rd_data (bus.rd_data)
   );

   assign bus.line_ready = line_ready_q;
   assign bus.overflow   = overflow_q;
   assign bus.line_count = line_count_q;

endmodule

// File: tb/tb_spectrum_line_buffer.sv
// Directed bench for spectrum_line_buffer: a table of line scenarios with
// hand-computed flags and read-back patterns, plus hand sequences for
// ack handling and mid-line reset.
module tb_spectrum_line_buffer;

   localparam int LOG_LAT = 3;

   logic       clk;
   logic       resetn;
   logic [7:0] bin_data;
   logic [7:0] mag_pipe [LOG_LAT];

   int total;
   int bad;

   spectrum_line_buffer_if bus_if ();

   spectrum_line_buffer #(
      .NBINS   (256),
      .ADDR_W  (8),
      .LOG_LAT (LOG_LAT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream log-magnitude stage stand-in: LOG_LAT ready-qualified registers.
   always_ff @(posedge clk) begin
      if (bus_if.ready) begin
         mag_pipe[0] <= bin_data;
         for (int i = 1; i < LOG_LAT; i++) begin
            mag_pipe[i] <= mag_pipe[i-1];
         end
      end
   end
   assign bus_if.log_mag = mag_pipe[LOG_LAT-1];

   typedef struct {
      string name;
      int    pat;      // pattern streamed
      int    last_at;  // bin carrying bin_last (255 = full line)
      int    toggle;   // ready alternates 1,0
      int    ack_same; // line_ack in the completing cycle
      int    ack_after;// release the line after the read-back
      int    rdy_pre;  // line_ready before the final write
      int    exp_rdy;
      int    exp_ovf;
      int    exp_cnt;
      int    lo_pat;   // expected pattern at addresses <= split
      int    hi_pat;   // expected pattern above split
      int    split;
   } line_vec_t;

   function automatic logic [7:0] pat(input int p, input int a);
      logic [7:0] av;
      av = a[7:0];
      case (p)
         0:       return av;
         1:       return 8'd255 - av;
         2:       return av ^ 8'hA5;
         default: return av + 8'h40;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm, input int rdy, input int ovf, input int cnt);
      chk({nm, " line_ready"}, 32'(bus_if.line_ready), 32'(rdy));
      chk({nm, " overflow"},   32'(bus_if.overflow),   32'(ovf));
      chk({nm, " line_count"}, 32'(bus_if.line_count), 32'(cnt));
   endtask

   task automatic pulse_ack(input string nm);
      bus_if.line_ack = 1'b1;
      @(negedge clk);
      bus_if.line_ack = 1'b0;
      chk({nm, " line_ready after ack"}, 32'(bus_if.line_ready), 32'd0);
   endtask

   task automatic apply_line(input line_vec_t v);
      for (int i = 0; i <= v.last_at; i++) begin
         bus_if.ready     = 1'b1;
         bus_if.bin_valid = 1'b1;
         bus_if.bin_last  = (i == v.last_at);
         bin_data         = pat(v.pat, i);
         @(negedge clk);
         if (v.toggle != 0) begin
            // Stalled cycle with junk on the inputs: nothing may be sampled.
            bus_if.ready     = 1'b0;
            bus_if.bin_valid = 1'b1;
            bus_if.bin_last  = 1'b1;
            bin_data         = 8'hEE;
            @(negedge clk);
         end
      end
      bus_if.ready     = 1'b1;
      bus_if.bin_valid = 1'b0;
      bus_if.bin_last  = 1'b0;
      bin_data         = 8'h00;
      for (int k = 1; k <= LOG_LAT; k++) begin
         chk($sformatf("%s line_ready pre %0d", v.name, k), 32'(bus_if.line_ready), 32'(v.rdy_pre));
         bus_if.line_ack = (v.ack_same != 0) && (k == LOG_LAT);
         @(negedge clk);
      end
      bus_if.line_ack = 1'b0;
      chk_idle_outputs(v.name, v.exp_rdy, v.exp_ovf, v.exp_cnt);
      for (int a = 0; a < 256; a++) begin
         bus_if.rd_addr = 8'(a);
         @(negedge clk);
         chk($sformatf("%s rd_data[%0d]", v.name, a), 32'(bus_if.rd_data),
             32'(pat((a <= v.split) ? v.lo_pat : v.hi_pat, a)));
      end
      if (v.ack_after != 0) begin
         pulse_ack(v.name);
      end
   endtask

   line_vec_t tbl [6];
   line_vec_t after_rst;

   initial begin
      total = 0;
      bad   = 0;
      //             name              pat last tog as aa pre rdy ovf cnt lo hi split
      tbl[0] = '{"full_pat0",         0, 255, 0, 0, 0, 0, 1, 0, 1, 0, 0, 255};
      tbl[1] = '{"ack_same_pat1",     1, 255, 0, 1, 0, 1, 1, 0, 2, 1, 1, 255};
      tbl[2] = '{"dropped_pat2",      2, 255, 0, 0, 1, 1, 1, 1, 2, 1, 1, 255};
      tbl[3] = '{"toggled_pat3",      3, 255, 1, 0, 1, 0, 1, 1, 3, 3, 3, 255};
      tbl[4] = '{"short99_pat2",      2,  99, 0, 0, 1, 0, 1, 1, 4, 2, 1,  99};
      tbl[5] = '{"after_short_pat0",  0, 255, 0, 0, 0, 0, 1, 1, 5, 0, 0, 255};
      after_rst = '{"after_reset_pat3", 3, 255, 0, 0, 0, 0, 1, 0, 1, 3, 3, 255};

      resetn           = 1'b0;
      bus_if.ready     = 1'b0;
      bus_if.bin_valid = 1'b0;
      bus_if.bin_last  = 1'b0;
      bus_if.rd_addr   = 8'd0;
      bus_if.line_ack  = 1'b0;
      bin_data         = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk_idle_outputs("reset", 0, 0, 0);
      chk("reset rd_data", 32'(bus_if.rd_data), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         apply_line(tbl[t]);
      end

      // Release, then an ack while EMPTY must change nothing.
      pulse_ack("release");
      pulse_ack("ack_in_empty");
      chk_idle_outputs("ack_in_empty", 0, 1, 5);

      // Reset in the middle of a line.
      for (int i = 0; i < 50; i++) begin
         bus_if.ready     = 1'b1;
         bus_if.bin_valid = 1'b1;
         bus_if.bin_last  = 1'b0;
         bin_data         = pat(1, i);
         @(negedge clk);
      end
      resetn = 1'b0;
      @(negedge clk);
      resetn           = 1'b1;
      bus_if.bin_valid = 1'b0;
      chk_idle_outputs("mid_reset", 0, 0, 0);
      chk("mid_reset rd_data", 32'(bus_if.rd_data), 32'd0);
      @(negedge clk);
      apply_line(after_rst);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spectrum_line_buffer.md
SPECTRUM_LINE_BUFFER -- requirements
Module: spectrum_line_buffer

Interface
REQ-001 Parameter: NBINS, 256, bins per spectrum line (power of two).
REQ-002 Parameter: ADDR_W, 8, log2(NBINS).
REQ-003 Parameter: LOG_LAT, 3, ready-qualified latency of the upstream log-magnitude stage.
REQ-004 Port: clk  in  1  clock; reset resetn, synchronous, active-low.
REQ-005 Port: resetn  in  1  synchronous active-low reset.
REQ-006 Port: ready  in  1  pipeline advance enable, same signal that drives the log-magnitude stage.
REQ-007 Port: bin_valid  in  1  complex bin valid, timed with the log-magnitude stage inputs.
REQ-008 Port: bin_last  in  1  last bin of line, timed with bin_valid.
REQ-009 Port: log_mag  in  8  registered log-magnitude output of the upstream stage.
REQ-010 Port: rd_addr  in  ADDR_W  reader bin address.
REQ-011 Port: rd_data  out  8  bin value of the published line.
REQ-012 Port: line_ready  out  1  a complete line is published and held for the reader.
REQ-013 Port: line_ack  in  1  reader has finished with the published line.
REQ-014 Port: overflow  out  1  sticky; a completed line was dropped.
REQ-015 Port: line_count  out  16  number of published lines, wraps modulo 2^16.

Function
REQ-016 Valid/last alignment: LOG_LAT-deep shift registers for bin_valid and bin_last; shift only on cycles with ready=1.
REQ-017 Write enable wr_en = ready AND valid_d[LOG_LAT-1]; the current log_mag is written to the write bank at wr_ptr; each sample is written exactly once.
REQ-018 ready=0: no shift, no write, wr_ptr held.
REQ-019 wr_ptr increments by 1 per write.
REQ-020 Line completion: a write with last_d[LOG_LAT-1]=1, or a write at wr_ptr=NBINS-1; wr_ptr returns to 0 on the following cycle.
REQ-021 Short lines (last before NBINS-1): bins above the last written address keep their stale contents.
REQ-022 Line FSM: EMPTY (line_ready=0) and HELD (line_ready=1).
REQ-023 Completion in EMPTY: swap wr_bank/rd_bank, go to HELD, increment line_count.
REQ-024 line_ack in HELD without completion: go to EMPTY next cycle.
REQ-025 line_ack in EMPTY: ignored.
REQ-026 Completion in HELD with line_ack in the same cycle: swap banks, stay in HELD, increment line_count, no overflow.
REQ-027 Completion in HELD without line_ack: no swap; line dropped; overflow set to 1; line_count unchanged; the next line overwrites the same write bank.
REQ-028 Read: rd_data = bank[rd_bank][rd_addr], registered, 1-cycle latency, independent of ready.
REQ-029 rd_data after a swap reflects the new rd_bank from the first read issued on the cycle after the swap.

Reset
REQ-030 Under resetn=0 at a clock edge: clear all delay registers; wr_ptr=0; wr_bank=0; rd_bank=1; state EMPTY; line_ready=0; overflow=0; line_count=0; rd_data=0.
REQ-031 RAM contents are not cleared by reset.
REQ-032 Reset mid-line: discard the partial line; the first write after reset goes to address 0 of bank 0.

Structure
REQ-033 Shared package spectrum_pkg holds NBINS, ADDR_W, LOG_LAT and MAG_W=8, all shared with the log-magnitude stage.
REQ-034 One sub-module, spectrum_bank_ram: simple dual-port 2*NBINS x 8, 1 write port, 1 registered read port, address = {bank, addr}.
REQ-035 Line FSM, pointers and counters live in the top module.

Verification
REQ-036 256 consecutive valid bins with ready=1 and log_mag=address -> line_ready rises on the cycle after the write to address 255; reads of addresses 0..255 return 0..255 at 1-cycle latency; line_count=1.
REQ-037 Same stream with ready toggling 1,0,1,0 -> identical RAM contents and identical line_count; no sample is duplicated or lost.
REQ-038 Second line completes while HELD and line_ack=0 -> overflow=1; rd_data still returns line 1; line_count=1.
REQ-039 line_ack in the same cycle as second-line completion -> line_ready stays 1; line 2 (log_mag=255-address) is readable; overflow=0; line_count=2.
REQ-040 bin_last on bin 99 -> publish after write at address 99; the next line starts at address 0; addresses 100..255 hold stale data.
REQ-041 resetn pulsed at bin 50 -> all outputs return to their reset values; the next 256-bin line publishes normally with line_count=1.
